// File: rtl/load_store_unit_if.sv
// Execute-stage to LSU request/response handshake bundle.
// master = pipeline side driving requests, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_is_load;
  logic        resp_fault;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_is_load, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage controller: one load/store at a time, alignment/range check, tagged result.
// Optional LSU_STATS_EN adds saturating 16-bit load/store/fault counters.
module load_store_unit #(
  parameter int MEM_ADDR_W  = 12,
  parameter int MEM_BYTES   = 1024,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  load_store_unit_if.slave      cpu,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wr_data,
  output logic                  mem_we,
  output logic [2:0]            mem_read_size,
  input  logic [31:0]           mem_rd_data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]           stat_loads,
  output logic [15:0]           stat_stores,
  output logic [15:0]           stat_faults
`endif
);

  localparam logic [2:0] MEM_BYTE_SIGNED       = 3'd0;
  localparam logic [2:0] MEM_HALFWORD_SIGNED   = 3'd1;
  localparam logic [2:0] MEM_WORD_SIGNED       = 3'd2;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'd4;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_n;

  logic                  we_q;
  logic                  is_load_q;
  logic                  fault_q;
  logic [2:0]            size_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic [4:0]            rd_q;

  logic        size_ok;
  logic        misalign;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        req_fault;

  // 33-bit end address so that accesses wrapping past 2^32 fault on range.
  always_comb begin
    size_ok  = 1'b1;
    misalign = 1'b0;
    nbytes   = 3'd1;
    case (cpu.req_size)
      MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED: nbytes = 3'd1;
      MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: begin
        nbytes   = 3'd2;
        misalign = cpu.req_addr[0];
      end
      MEM_WORD_SIGNED: begin
        nbytes   = 3'd4;
        misalign = |cpu.req_addr[1:0];
      end
      default: size_ok = 1'b0;
    endcase
    end_addr  = {1'b0, cpu.req_addr} + {30'd0, nbytes};
    req_fault = !size_ok || ((CHECK_ALIGN != 0) && misalign) || (end_addr > 33'(MEM_BYTES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cpu.req_valid) state_n = req_fault ? RESP : ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (cpu.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cpu.req_ready  = (state == IDLE);
    cpu.resp_valid = (state == RESP);
    mem_we         = (state == ACCESS) && we_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      fault_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      rd_q      <= '0;
    end else begin
      if (state == IDLE && cpu.req_valid) begin
        we_q      <= cpu.req_we;
        is_load_q <= ~cpu.req_we;
        fault_q   <= req_fault;
        size_q    <= cpu.req_size;
        addr_q    <= cpu.req_addr[MEM_ADDR_W-1:0];
        wdata_q   <= cpu.req_wdata;
        data_q    <= '0;
        rd_q      <= cpu.req_rd;
      end
      if (state == ACCESS && !we_q) data_q <= mem_rd_data;
    end
  end

  assign mem_addr          = addr_q;
  assign mem_wr_data       = wdata_q;
  assign mem_read_size     = size_q;
  assign cpu.resp_data     = data_q;
  assign cpu.resp_rd       = rd_q;
  assign cpu.resp_is_load  = is_load_q;
  assign cpu.resp_fault    = fault_q;

`ifdef LSU_STATS_EN
  logic resp_fire;
  assign resp_fire = (state == RESP) && cpu.resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_faults <= '0;
    end else if (resp_fire) begin
      if (fault_q) begin
        if (stat_faults != '1) stat_faults <= stat_faults + 16'd1;
      end else if (is_load_q) begin
        if (stat_loads != '1) stat_loads <= stat_loads + 16'd1;
      end else begin
        if (stat_stores != '1) stat_stores <= stat_stores + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage controller between the execute stage and the byte-addressed data memory.
- Accepts one load or store request at a time over a valid/ready handshake and checks alignment and range.
- Drives the data-memory port (address, write data, write enable, size code), captures load data, and returns a tagged result to writeback over a second valid/ready handshake.
- Size codes are the Instructions package constants: MEM_BYTE_SIGNED, MEM_HALFWORD_SIGNED, MEM_WORD_SIGNED, MEM_BYTE_UNSIGNED, MEM_HALFWORD_UNSIGNED.

Parameters:
- MEM_ADDR_W, 12, width of the data-memory address port.
- MEM_BYTES, 1024, number of implemented data-memory bytes; used for the range check.
- CHECK_ALIGN, 1, when 1, misaligned halfword/word accesses fault; when 0, only the range check applies.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  3  size code
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data
- req_rd  in  5  destination register tag
- resp_valid  out  1  result present
- resp_ready  in  1  writeback accepts result
- resp_data  out  32  load data (0 for stores/faults)
- resp_rd  out  5  echoed tag
- resp_is_load  out  1  echoed ~req_we
- resp_fault  out  1  access rejected
- mem_addr  out  MEM_ADDR_W  to data memory
- mem_wr_data  out  32  to data memory
- mem_we  out  1  to data memory
- mem_read_size  out  3  to data memory size input
- mem_rd_data  in  32  from data memory (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; all registered fields=0; outputs req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_is_load=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wr_data=0, mem_read_size=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register we/size/addr/wdata/rd and compute fault.
  - fault=0 -> ACCESS; fault=1 -> RESP with resp_fault=1 and no memory access.
- Fault conditions (any one faults):
  - size code is not one of the five constants;
  - CHECK_ALIGN=1 and a halfword access has addr[0]!=0;
  - CHECK_ALIGN=1 and a word access has addr[1:0]!=0;
  - addr + nbytes > MEM_BYTES, where nbytes=1/2/4, evaluated at 33-bit width so wrap-around near 2^32 faults.
  - Store with MEM_WORD_SIGNED is a word store; unsigned byte/halfword codes are legal for stores.
- ACCESS (exactly one cycle):
  - mem_addr=addr_q[MEM_ADDR_W-1:0], mem_read_size=size_q, mem_wr_data=wdata_q.
  - mem_we=we_q, asserted for this cycle only.
  - Loads latch mem_rd_data into resp_data at the end of the cycle.
  - Go to RESP.
- mem_addr, mem_read_size and mem_wr_data hold their registered values in all states; mem_we is 1 only in ACCESS.
- RESP:
  - resp_valid=1; payload stable until handshake.
  - On resp_ready, go to IDLE; req_ready rises the next cycle. No request overlap.
- Latency: request accepted in cycle N; good access: mem_we/read in N+1, resp_valid in N+2. Fault: resp_valid in N+1.
- resp_valid held with resp_ready=0 for any number of cycles: payload unchanged, req_ready=0.
- Reset asserted mid-ACCESS: mem_we drops immediately, the in-flight store is abandoned, and no response is produced.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_faults, each 16 bits.
  - stat_loads counts completed non-faulting loads; stat_stores counts completed non-faulting stores; stat_faults counts faulted requests.
  - Each counter increments on the resp handshake and saturates at 16'hFFFF.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word store, then word load: store addr=0x10, wdata=0xDEADBEEF, size=WORD -> mem_we=1 for exactly one cycle at N+1, addr 0x10. Load from 0x10, rd=5 -> resp_data=0xDEADBEEF, resp_rd=5, resp_valid at N+2.
- Signed and unsigned byte loads: memory byte 0x80 at addr 3. BYTE_SIGNED load -> resp_data=0xFFFFFF80; BYTE_UNSIGNED load -> resp_data=0x00000080.
- Misaligned access: word load at 0x12 -> resp_fault=1 at N+1, mem_we never 1. Halfword store at 0x7 -> fault, memory unchanged.
- Out-of-range access: word store at 1021 -> fault; word store at 1020 -> succeeds. Load at 0xFFFFFFFE halfword -> fault (wrap).
- Backpressure: resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0. Release -> IDLE, next request accepted.
- Reset during ACCESS of a store to 0x20 -> mem_we=0 immediately, resp_valid=0, memory byte unchanged. With LSU_STATS_EN defined, all counters read 0 after reset.
